fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch front end for the pipelined core. It replaces the PC register, PC-increment logic and Fetch/Decode pipeline register. It talks to instruction memory through a request/response handshake that tolerates variable latency, and buffers up to DEPTH instructions in a prefetch queue. It presents one instruction per cycle to Decode, with stall (hold) and redirect (flush and re-steer) support driven by Execute and the hazard unit.

## Interface
- ADDR_WIDTH, 32, PC and memory address width
- INSTR_WIDTH, 32, instruction width
- DEPTH, 4, prefetch queue entries; power of two, ≥2
- OFFSET, 4, PC increment
- RESET_PC, 0, first fetch address after reset
- NOP, 32'h00000013, bubble instruction (addi x0,x0,0)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous and active-low (0 = reset)
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_addr  out  ADDR_WIDTH  fetch address (= fetch PC)
- imem_rsp_valid  in  1  response valid; responses return in request order
- imem_rdata  in  INSTR_WIDTH  response instruction
- redirect  in  1  taken branch/jump from Execute (pcSrcE)
- redirect_pc  in  ADDR_WIDTH  new PC (PCTargetE)
- stall  in  1  hold Decode register (StallD)
- InstrD  out  INSTR_WIDTH  instruction to Decode
- PCd  out  ADDR_WIDTH  PC of InstrD
- PCPlus4D  out  ADDR_WIDTH  PCd + OFFSET
- validD  out  1  InstrD is a real instruction

## Operation
- State:
  - fetch_pc
  - queue of DEPTH entries {pc, instr, filled}, with head/tail pointers and alloc_count
  - outstanding counter (accepted requests not yet answered, 0..DEPTH)
  - drop counter (stale responses still to discard, 0..DEPTH)
  - Decode output register
- Issue:
  - imem_req_valid = !redirect && alloc_count < DEPTH && outstanding < DEPTH.
  - Both conditions use registered counts. A pop in the same cycle does not free a slot for that cycle's issue.
  - On handshake (valid && ready):
    - allocate the tail entry with pc = fetch_pc, filled = 0
    - fetch_pc += OFFSET, wrapping modulo 2^ADDR_WIDTH
    - outstanding++
  - While valid && !ready: imem_addr holds stable.
- Response (rsp_valid):
  - If drop > 0: discard the response, drop--.
  - Otherwise: write instr into the oldest unfilled entry and set filled = 1.
  - In both cases outstanding--.
- Decode register, priority highest first:
  1. redirect: validD←0, InstrD←NOP; overrides stall.
  2. stall: hold all outputs; no pop.
  3. head entry filled: load InstrD/PCd/PCPlus4D from it, validD←1, pop.
  4. Otherwise: validD←0, InstrD←NOP (bubble). PCd/PCPlus4D hold.
- Redirect cycle:
  - fetch_pc←redirect_pc.
  - Queue emptied: pointers equal, alloc_count←0.
  - drop←outstanding − (rsp_valid ? 1 : 0), i.e. every request still in flight is stale.
  - A response arriving in the redirect cycle is discarded.
  - No request is issued in this cycle.
- Simultaneous events:
  - Response and pop of the same entry in one cycle is impossible: the entry is not filled until the next edge.
  - Allocate and pop in one cycle: alloc_count unchanged.
  - Response and issue in one cycle: outstanding unchanged.
- Reset (asynchronous, any time, including mid-operation):
  - fetch_pc = RESET_PC
  - queue empty, outstanding = 0, drop = 0
  - InstrD = NOP, PCd = 0, PCPlus4D = 0, validD = 0
  - imem_req_valid may assert in the first cycle after reset release.
  - Responses to pre-reset requests are not the responsibility of this block; the memory is reset together with it.

## Timing
- Request accepted at cycle t, response at cycle r ≥ t+1:
  - entry filled at the end of r
  - Decode register loaded at the end of r+1
  - validD high in cycle r+2
- Steady-state throughput with single-cycle memory and always-ready: one instruction per cycle.
- Redirect asserted in cycle t:
  - validD = 0 in cycle t+1
  - first request to redirect_pc issued in cycle t+1
- Stall is sampled every cycle. The queue keeps filling during a stall until alloc_count = DEPTH.
- No combinational path from imem_rsp_valid or imem_rdata to any output. imem_req_valid depends combinationally on redirect only.

## Test plan
- **Streaming.** Reset release, then single-cycle memory (rdata = addr), ready = 1. Required: validD first high in cycle 3 with PCd = 0, then PCd = 4, 8, 12 on consecutive cycles, PCPlus4D = PCd + 4.
- **Stall.** Stall for 6 cycles mid-stream (DEPTH = 4). Required: outputs held; imem_req_valid falls once 4 entries are allocated; after release, PCs continue with no gap and no duplicate.
- **Redirect with two in flight.** Memory latency 3 cycles, redirect to 0x100 with two requests in flight. Required: both stale responses dropped; validD = 0 for at least one cycle; the next valid instruction has PCd = 0x100.
- **Redirect with stall.** Redirect and stall in the same cycle. Required: next cycle validD = 0 and InstrD = 0x00000013; fetch resumes at redirect_pc.
- **Backpressure.** imem_req_ready = 0 for 5 cycles. Required: imem_addr constant and imem_req_valid high throughout; on the accept cycle fetch_pc advances by exactly 4.
- **Reset mid-operation.** Assert rst = 0 asynchronously mid-stream with a full queue. Required: validD = 0 and InstrD = NOP immediately, without waiting for a clock edge; after release the first request is to RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC generation, in-order request/response handshake with
// instruction memory, DEPTH-entry prefetch queue and the Fetch/Decode pipeline register.
module fetch_unit #(
  parameter int                     ADDR_WIDTH  = 32,
  parameter int                     INSTR_WIDTH = 32,
  parameter int                     DEPTH       = 4,
  parameter int                     OFFSET      = 4,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0] NOP         = 32'h00000013
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   redirect,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  input  logic                   stall,
  output logic [INSTR_WIDTH-1:0] InstrD,
  output logic [ADDR_WIDTH-1:0]  PCd,
  output logic [ADDR_WIDTH-1:0]  PCPlus4D,
  output logic                   validD
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]      DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP    = ADDR_WIDTH'(OFFSET);
  localparam logic [PTR_W-1:0]      PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);

  logic [ADDR_WIDTH-1:0]  fetchPc;
  logic [PTR_W-1:0]       headPtr;
  logic [PTR_W-1:0]       tailPtr;
  logic [PTR_W-1:0]       fillPtr;
  logic [CNT_W-1:0]       allocCount;
  logic [CNT_W-1:0]       outstanding;
  logic [CNT_W-1:0]       dropCount;

  logic [ADDR_WIDTH-1:0]  qPc    [DEPTH];
  logic [INSTR_WIDTH-1:0] qInstr [DEPTH];
  logic [DEPTH-1:0]       qFilled;

  logic accept;
  logic headFilled;
  logic pop;
  logic dropRsp;
  logic fillRsp;

  // Issue decisions use only registered counts, so a same-cycle pop never frees a slot early.
  assign imem_req_valid = !redirect && (allocCount < DEPTH_C) && (outstanding < DEPTH_C);
  assign imem_addr      = fetchPc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign headFilled     = (allocCount != '0) && qFilled[headPtr];
  assign pop            = !redirect && !stall && headFilled;
  assign dropRsp        = imem_rsp_valid && (redirect || (dropCount != '0));
  assign fillRsp        = imem_rsp_valid && !dropRsp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetchPc     <= RESET_PC;
      headPtr     <= '0;
      tailPtr     <= '0;
      fillPtr     <= '0;
      allocCount  <= '0;
      outstanding <= '0;
      dropCount   <= '0;
    end else if (redirect) begin
      // Everything still in flight belongs to the abandoned path and must be discarded.
      fetchPc     <= redirect_pc;
      headPtr     <= '0;
      tailPtr     <= '0;
      fillPtr     <= '0;
      allocCount  <= '0;
      dropCount   <= outstanding - CNT_W'(imem_rsp_valid);
      outstanding <= outstanding - CNT_W'(imem_rsp_valid);
    end else begin
      if (accept) begin
        fetchPc <= fetchPc + STEP;
        tailPtr <= tailPtr + PTR_ONE;
      end
      if (pop) begin
        headPtr <= headPtr + PTR_ONE;
      end
      if (fillRsp) begin
        fillPtr <= fillPtr + PTR_ONE;
      end
      if (dropRsp) begin
        dropCount <= dropCount - CNT_ONE;
      end
      if (accept && !pop) begin
        allocCount <= allocCount + CNT_ONE;
      end else if (!accept && pop) begin
        allocCount <= allocCount - CNT_ONE;
      end
      if (accept && !imem_rsp_valid) begin
        outstanding <= outstanding + CNT_ONE;
      end else if (!accept && imem_rsp_valid) begin
        outstanding <= outstanding - CNT_ONE;
      end
    end
  end

  // Stale filled bits after a redirect are harmless: allocation clears the bit of its entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      qFilled <= '0;
    end else begin
      if (accept) begin
        qFilled[tailPtr] <= 1'b0;
      end
      if (fillRsp) begin
        qFilled[fillPtr] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      qPc[tailPtr] <= fetchPc;
    end
    if (fillRsp) begin
      qInstr[fillPtr] <= imem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      InstrD   <= NOP;
      PCd      <= '0;
      PCPlus4D <= '0;
      validD   <= 1'b0;
    end else if (redirect) begin
      InstrD <= NOP;
      validD <= 1'b0;
    end else if (stall) begin
      InstrD <= InstrD;
    end else if (headFilled) begin
      InstrD   <= qInstr[headPtr];
      PCd      <= qPc[headPtr];
      PCPlus4D <= qPc[headPtr] + STEP;
      validD   <= 1'b1;
    end else begin
      InstrD <= NOP;
      validD <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory model whose instruction word equals its
// address, with hand-computed cycle-by-cycle expectations for each scenario.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        rst;
  logic        reqValid;
  logic        reqReady;
  logic [31:0] addr;
  logic        rspValid;
  logic [31:0] rdata;
  logic        redirect;
  logic [31:0] redirectPc;
  logic        stall;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic [31:0] pcPlus4D;
  logic        validD;

  int checks = 0;
  int errors = 0;

  int          memLatency = 1;
  int          memCycle   = 0;
  logic        memHs;
  logic [31:0] memHsAddr;
  logic [31:0] memAddrQ[$];
  int          memDueQ[$];

  fetch_unit dut (
    .clk(clk),
    .rst(rst),
    .imem_req_valid(reqValid),
    .imem_req_ready(reqReady),
    .imem_addr(addr),
    .imem_rsp_valid(rspValid),
    .imem_rdata(rdata),
    .redirect(redirect),
    .redirect_pc(redirectPc),
    .stall(stall),
    .InstrD(instrD),
    .PCd(pcD),
    .PCPlus4D(pcPlus4D),
    .validD(validD)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: handshake sampled mid-cycle, response memLatency cycles after acceptance.
  initial begin
    rspValid = 1'b0;
    rdata    = '0;
    forever begin
      @(negedge clk);
      memHs     = reqValid && reqReady && rst;
      memHsAddr = addr;
      @(posedge clk);
      #1;
      memCycle++;
      if (!rst) begin
        memAddrQ.delete();
        memDueQ.delete();
        rspValid = 1'b0;
      end else begin
        if (memHs) begin
          memAddrQ.push_back(memHsAddr);
          memDueQ.push_back(memCycle - 1 + memLatency);
        end
        if (memAddrQ.size() != 0 && memDueQ[0] <= memCycle) begin
          rspValid = 1'b1;
          rdata    = memAddrQ.pop_front();
          void'(memDueQ.pop_front());
        end else begin
          rspValid = 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drives the inputs for the next cycle, then returns mid-cycle ready for sampling.
  task automatic applyStimulus(input logic st, input logic rd, input logic [31:0] rpc, input logic rdy);
    @(posedge clk);
    #1;
    stall      = st;
    redirect   = rd;
    redirectPc = rpc;
    reqReady   = rdy;
    @(negedge clk);
  endtask

  task automatic releaseReset();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    stall    = 1'b0;
    redirect = 1'b0;
    reqReady = 1'b1;
    @(negedge clk);
  endtask

  task automatic checkDecode(input string tag, input logic v, input logic [31:0] pc);
    checkOutput({tag, "Valid"}, 32'(validD), 32'(v));
    if (v) begin
      checkOutput({tag, "Pc"}, pcD, pc);
      checkOutput({tag, "Instr"}, instrD, pc);
      checkOutput({tag, "Pc4"}, pcPlus4D, pc + 32'd4);
    end
  endtask

  initial begin
    rst        = 1'b0;
    stall      = 1'b0;
    redirect   = 1'b0;
    redirectPc = '0;
    reqReady   = 1'b1;
    memLatency = 1;

    repeat (2) @(negedge clk);
    checkOutput("rstValid", 32'(validD), 32'd0);
    checkOutput("rstInstr", instrD, NOP);
    checkOutput("rstPc", pcD, 32'd0);
    checkOutput("rstPc4", pcPlus4D, 32'd0);

    // Streaming from reset, single-cycle memory
    releaseReset();
    checkOutput("c0ReqValid", 32'(reqValid), 32'd1);
    checkOutput("c0Addr", addr, 32'd0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkDecode("c1", 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkDecode("c2", 1'b0, '0);
    for (int k = 3; k <= 6; k++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      checkDecode("stream", 1'b1, 32'(4 * (k - 3)));
    end

    // Stall cycles 7..12: decode holds PC 16, requests stop once four entries are allocated
    for (int k = 7; k <= 12; k++) begin
      applyStimulus(1'b1, 1'b0, '0, 1'b1);
      checkDecode("stallHold", 1'b1, 32'd16);
      checkOutput("stallReqValid", 32'(reqValid), (k <= 8) ? 32'd1 : 32'd0);
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkDecode("stallRelease", 1'b1, 32'd16);
    checkOutput("stallReleaseReq", 32'(reqValid), 32'd0);
    for (int k = 14; k <= 19; k++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      checkDecode("postStall", 1'b1, 32'(20 + 4 * (k - 14)));
      if (k == 14) checkOutput("postStallAddr", addr, 32'd36);
    end

    // Redirect with two requests in flight, latency 3
    rst = 1'b0;
    memLatency = 3;
    repeat (2) @(negedge clk);
    releaseReset();
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b1);
    checkOutput("redirReqValid", 32'(reqValid), 32'd0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("redirAddr", addr, 32'h100);
    checkOutput("redirNewReq", 32'(reqValid), 32'd1);
    checkDecode("redirC3", 1'b0, '0);
    for (int k = 4; k <= 7; k++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      checkDecode("redirBubble", 1'b0, '0);
    end
    for (int k = 8; k <= 10; k++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      checkDecode("redirStream", 1'b1, 32'h100 + 32'(4 * (k - 8)));
    end

    // Redirect and stall in the same cycle, latency 1
    rst = 1'b0;
    memLatency = 1;
    repeat (2) @(negedge clk);
    releaseReset();
    for (int k = 1; k <= 4; k++) applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkDecode("rsC4", 1'b1, 32'd4);
    applyStimulus(1'b1, 1'b1, 32'h200, 1'b1);
    checkOutput("rsReqValid", 32'(reqValid), 32'd0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("rsValid", 32'(validD), 32'd0);
    checkOutput("rsInstr", instrD, NOP);
    checkOutput("rsAddr", addr, 32'h200);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkDecode("rsC7", 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkDecode("rsC8", 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkDecode("rsC9", 1'b1, 32'h200);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkDecode("rsC10", 1'b1, 32'h204);

    // Backpressure cycles 11..15: address held, request held
    for (int k = 11; k <= 15; k++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      checkOutput("bpReqValid", 32'(reqValid), 32'd1);
      checkOutput("bpAddr", addr, 32'h214);
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("bpAcceptAddr", addr, 32'h214);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("bpNextAddr", addr, 32'h218);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkDecode("bpC19", 1'b1, 32'h214);

    // Fill the queue under stall, then reset asynchronously mid-cycle
    for (int k = 20; k <= 25; k++) begin
      applyStimulus(1'b1, 1'b0, '0, 1'b1);
      checkDecode("fillHold", 1'b1, 32'h218);
    end
    checkOutput("fullReqValid", 32'(reqValid), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("asyncValid", 32'(validD), 32'd0);
    checkOutput("asyncInstr", instrD, NOP);
    checkOutput("asyncPc", pcD, 32'd0);
    repeat (2) @(negedge clk);
    releaseReset();
    checkOutput("postRstReq", 32'(reqValid), 32'd1);
    checkOutput("postRstAddr", addr, 32'd0);
    for (int k = 1; k <= 3; k++) applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkDecode("postRstC3", 1'b1, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
